// File: rtl/qif_neuron_scheduler_pkg.sv
// Shared constants, FSM state type and output saturation for the QIF neuron scheduler.
package qif_pkg;

  localparam int DATA_W       = 8;
  localparam int ACC_W        = 26;
  localparam int VPEAK_DEF    = 50;
  localparam int VRESET_DEF   = -20;
  localparam int A_DEF        = 32;
  localparam int SQ_SHIFT_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_EMIT
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  function automatic logic signed [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] x);
    if (x > SAT_HI)
      return DATA_W'(127);
    else if (x < SAT_LO)
      return DATA_W'(-128);
    else
      return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/qif_neuron_scheduler_update.sv
// Combinational QIF membrane update f(v,b) and spike-threshold compare for one lane.
module qif_update
  import qif_pkg::*;
#(
  parameter int A        = A_DEF,
  parameter int SQ_SHIFT = SQ_SHIFT_DEF,
  parameter int VPEAK    = VPEAK_DEF
) (
  input  logic [DATA_W-1:0] v,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] v_next,
  output logic              spike
);

  localparam logic signed [ACC_W-1:0]  GAIN = ACC_W'(A % 256);
  localparam logic signed [DATA_W-1:0] PEAK = DATA_W'(VPEAK);

  logic signed [DATA_W-1:0] vs;
  logic signed [DATA_W-1:0] bs;
  logic signed [15:0]       v16;
  logic signed [15:0]       sq;
  logic signed [17:0]       s;
  logic signed [ACC_W-1:0]  p;

  assign vs = v;
  assign bs = b;

  // Widths are chosen so no intermediate can wrap for any 8-bit v, b and gain.
  always_comb begin
    v16    = 16'(vs);
    sq     = (v16 * v16) >>> SQ_SHIFT;
    s      = 18'(vs) + 18'(sq) + 18'(bs);
    p      = (ACC_W'(s) * GAIN) >>> 7;
    v_next = sat8(p);
    spike  = (vs >= PEAK);
  end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed sweep controller sharing one QIF update lane across N neurons,
// with spike events handed to the router through a valid/ready port.
module qif_neuron_scheduler
  import qif_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int A        = A_DEF,
  parameter int SQ_SHIFT = SQ_SHIFT_DEF,
  parameter int VPEAK    = VPEAK_DEF,
  parameter int VRESET   = VRESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [IDXW-1:0]   cfg_addr,
  input  logic [DATA_W-1:0] cfg_b,
  input  logic [IDXW-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_v,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [IDXW-1:0]   spk_idx,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun
);

  localparam logic signed [DATA_W-1:0] VRST = DATA_W'(VRESET);
  localparam logic [IDXW-1:0]          LAST = IDXW'(N - 1);

  state_t                   state;
  state_t                   state_nx;
  logic [IDXW-1:0]          idx;
  logic signed [DATA_W-1:0] v_mem [N];
  logic signed [DATA_W-1:0] b_mem [N];
  logic signed [DATA_W-1:0] v_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [DATA_W-1:0]        v_upd;
  logic                     spike;
  logic                     last;
  logic                     start;
  logic                     advance;

  qif_update #(
    .A        (A),
    .SQ_SHIFT (SQ_SHIFT),
    .VPEAK    (VPEAK)
  ) u_update (
    .v      (v_p0),
    .b      (b_p0),
    .v_next (v_upd),
    .spike  (spike)
  );

  assign last    = (idx == LAST);
  // The sweep_done cycle still counts as busy for tick acceptance.
  assign start   = (state == S_IDLE) && tick && !sweep_done;
  assign advance = ((state == S_UPDATE) && !spike) || ((state == S_EMIT) && spk_ready);
  assign spk_idx = idx;
  assign rd_v    = v_mem[rd_addr];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_UPDATE;
      S_UPDATE: begin
        if (spike)
          state_nx = S_EMIT;
        else
          state_nx = last ? S_IDLE : S_LOAD;
      end
      S_EMIT:   if (spk_ready) state_nx = last ? S_IDLE : S_LOAD;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    spk_valid = (state == S_EMIT);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx        <= '0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        v_mem[i] <= VRST;
        b_mem[i] <= '0;
      end
    end else begin
      sweep_done <= advance && last;
      if (tick && (busy || sweep_done))
        overrun <= 1'b1;
      if (advance)
        idx <= last ? '0 : idx + 1'b1;
      if (state == S_UPDATE)
        v_mem[idx] <= spike ? VRST : v_upd;
      if (cfg_we)
        b_mem[cfg_addr] <= cfg_b;
    end
  end

  // Stage p0: operands captured in LOAD, consumed by the update lane in UPDATE.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      v_p0 <= v_mem[idx];
      b_p0 <= b_mem[idx];
    end
  end

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Bench for qif_neuron_scheduler: constant tables, hand sequences and random sweeps vs a sweep-level model.
module tb_qif_neuron_scheduler;

  localparam int N = 4;

  typedef struct {
    int exp_v0;
    int exp_spk;
  } vec_t;

  typedef struct {
    int idx;
    int exp_v;
    int exp_v2;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_b = '0;
  logic [1:0] rd_addr = '0;
  logic       spk_ready = 1'b1;
  logic       ready2 = 1'b1;
  logic [7:0] rd_v, rd_v2;
  logic       spk_valid, busy, sweep_done, overrun;
  logic [1:0] spk_idx;
  logic       spk_valid2, busy2, sweep_done2, overrun2;
  logic [1:0] spk_idx2;

  int tests = 0;
  int fails = 0;
  int mv[N];
  int mb[N];
  vec_t b100_tab[4];
  rd_t  sat_tab[4];

  always #5 clk = ~clk;

  qif_neuron_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_b(cfg_b), .rd_addr(rd_addr), .rd_v(rd_v), .spk_valid(spk_valid),
    .spk_ready(spk_ready), .spk_idx(spk_idx), .busy(busy), .sweep_done(sweep_done),
    .overrun(overrun)
  );

  qif_neuron_scheduler #(.A(255)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_b(cfg_b), .rd_addr(rd_addr), .rd_v(rd_v2), .spk_valid(spk_valid2),
    .spk_ready(ready2), .spk_idx(spk_idx2), .busy(busy2), .sweep_done(sweep_done2),
    .overrun(overrun2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sv8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  // QIF rule with floor division written out explicitly, then clamped to 8 bits.
  function automatic int f_model(input int v, input int b, input int a);
    int sq, s, t, p;
    sq = (v * v) / 16;
    s  = v + sq + b;
    t  = s * a;
    p  = (t >= 0) ? t / 128 : -((-t + 127) / 128);
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0; cfg_we = 1'b0; spk_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = -20;
      mb[i] = 0;
    end
  endtask

  task automatic set_b(input int i, input int val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = i[1:0]; cfg_b = val[7:0];
    @(negedge clk);
    cfg_we = 1'b0;
    mb[i] = val;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_addr = i[1:0];
      #1;
      chk($sformatf("%s_v%0d", tag, i), sv8(rd_v), mv[i]);
    end
  endtask

  task automatic run_sweep(input int stall, input int tick_at, input int wr_at,
                           input int wr_val, input bit tick_done, output int nspk);
    int exp_spk[$];
    int got_spk[$];
    int pre[N];
    int n, stall_left, held_idx;
    bit held, busy_ok;
    pre = mv;
    for (int i = 0; i < N; i++) begin
      if (mv[i] >= 50) begin
        exp_spk.push_back(i);
        mv[i] = -20;
      end else begin
        mv[i] = f_model(mv[i], mb[i], 32);
      end
    end
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 0; stall_left = stall; held = 1'b0; busy_ok = 1'b1; held_idx = 0;
    while (n < 300 && !sweep_done) begin
      tick = (n == tick_at);
      cfg_we = (n == wr_at); cfg_addr = 2'd0; cfg_b = wr_val[7:0];
      if (!busy) busy_ok = 1'b0;
      spk_ready = 1'b1;
      if (spk_valid) begin
        if (held) chk("stall_idx_stable", int'(spk_idx), held_idx);
        if (stall_left > 0) begin
          spk_ready = 1'b0;
          stall_left--;
          held = 1'b1;
          held_idx = int'(spk_idx);
          if (int'(spk_idx) < N - 1) begin
            rd_addr = 2'(int'(spk_idx) + 1);
            #1;
            chk("stall_no_update", sv8(rd_v), pre[int'(spk_idx) + 1]);
          end
        end else begin
          got_spk.push_back(int'(spk_idx));
          held = 1'b0;
          stall_left = stall;
        end
      end
      @(negedge clk);
      n++;
    end
    tick = 1'b0; cfg_we = 1'b0; spk_ready = 1'b1;
    chk("sweep_cycles", n, 2 * N + exp_spk.size() * (1 + stall));
    chk("sweep_busy_high", int'(busy_ok), 1);
    chk("done_busy_low", int'(busy), 0);
    chk("spike_count", got_spk.size(), exp_spk.size());
    for (int i = 0; i < exp_spk.size() && i < got_spk.size(); i++)
      chk("spike_idx", got_spk[i], exp_spk[i]);
    if (wr_at >= 0) mb[0] = wr_val;
    if (tick_done) tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("done_one_cycle", int'(sweep_done), 0);
    if (tick_done) begin
      for (int k = 0; k < 4; k++) begin
        chk("tick_on_done_ignored", int'(busy), 0);
        @(negedge clk);
      end
    end
    read_all("sweep");
    nspk = got_spk.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nspk, n;
    b100_tab = '{'{26, 0}, '{42, 0}, '{63, 0}, '{-20, 1}};
    sat_tab  = '{'{0, 1, 9}, '{1, 1, 9}, '{2, -31, -128}, '{3, 33, 127}};

    // Reset state
    do_reset();
    chk("rst_spk_valid", int'(spk_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_spk_idx", int'(spk_idx), 0);
    for (int i = 0; i < N; i++) begin
      rd_addr = i[1:0];
      #1;
      chk("rst_rd_v", sv8(rd_v), -20);
    end

    // All B=0: each V becomes 1, no events, 2N cycles
    run_sweep(0, -1, -1, 0, 1'b0, nspk);
    chk("zero_b_nspk", nspk, 0);
    rd_addr = 2'd3;
    #1;
    chk("zero_b_v3", sv8(rd_v), 1);

    // B[0]=100 trajectory into a spike
    do_reset();
    set_b(0, 100);
    for (int t = 0; t < 4; t++) begin
      run_sweep(0, -1, -1, 0, 1'b0, nspk);
      rd_addr = 2'd0;
      #1;
      chk($sformatf("b100_v0_t%0d", t + 1), sv8(rd_v), b100_tab[t].exp_v0);
      chk($sformatf("b100_spk_t%0d", t + 1), nspk, b100_tab[t].exp_spk);
    end

    // Back-pressure: event held for 5 cycles, later neurons wait
    do_reset();
    set_b(0, 100);
    set_b(1, 60);
    for (int t = 0; t < 3; t++) run_sweep(0, -1, -1, 0, 1'b0, nspk);
    run_sweep(5, -1, -1, 0, 1'b0, nspk);
    chk("stall_nspk", nspk, 1);

    // Floor shift and saturation, default gain vs A=255
    do_reset();
    set_b(2, -128);
    set_b(3, 127);
    run_sweep(0, -1, -1, 0, 1'b0, nspk);
    for (int i = 0; i < 4; i++) begin
      rd_addr = sat_tab[i].idx[1:0];
      #1;
      chk($sformatf("sat_a32_v%0d", i), sv8(rd_v), sat_tab[i].exp_v);
      chk($sformatf("sat_a255_v%0d", i), sv8(rd_v2), sat_tab[i].exp_v2);
    end

    // Tick in the sweep_done cycle is ignored and flagged
    chk("overrun_before", int'(overrun), 0);
    run_sweep(0, -1, -1, 0, 1'b1, nspk);
    chk("overrun_tick_on_done", int'(overrun), 1);

    // Mid-sweep tick and mid-sweep B write to an already-processed neuron
    do_reset();
    chk("overrun_cleared", int'(overrun), 0);
    run_sweep(0, 3, 4, -50, 1'b0, nspk);
    chk("overrun_mid_sweep", int'(overrun), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_second_sweep", int'(busy), 0);
    end
    run_sweep(0, -1, -1, 0, 1'b0, nspk);

    // Random B values and back-pressure against the model
    do_reset();
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1)
        set_b(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)) - 128);
      run_sweep(int'($urandom_range(0, 2)), -1, -1, 0, 1'b0, nspk);
    end

    // Asynchronous reset while an event is pending
    do_reset();
    set_b(0, 100);
    for (int t = 0; t < 3; t++) run_sweep(0, -1, -1, 0, 1'b0, nspk);
    @(negedge clk);
    spk_ready = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 0;
    while (!spk_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("emit_reached", int'(spk_valid), 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst_spk_valid", int'(spk_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    for (int i = 0; i < N; i++) begin
      rd_addr = i[1:0];
      #1;
      chk("async_rst_v", sv8(rd_v), -20);
    end
    @(negedge clk);
    rst_n = 1'b0;
    spk_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
